wide_comparator_sequencer: RTL and testbench

Multi-cycle magnitude comparator for operands wider than one byte. It time-shares a single `eight_bit_comparator` instance, feeding it one byte per clock from least- to most-significant byte. Each byte's less/equal/greater result is registered and fed back as the cascade input for the next byte. Sits beside the datapath as the sequencing controller for the 8-bit comparator, with a start/busy/done handshake toward the requesting logic.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/eight_bit_comparator.sv | 29 ++
 rtl/wide_comparator_sequencer.sv | 123 ++++++++++++
 tb/tb_wide_comparator_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the byte-serial wide magnitude comparator.
package cmp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cmp_state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  // A fresh compare starts as "equal so far" so the first byte decides on its own.
  localparam cmp_res_t CASCADE_RESET = cmp_res_t'(3'b010);

  localparam cmp_res_t RESULT_RESET  = cmp_res_t'(3'b000);

endpackage

// File: rtl/eight_bit_comparator.sv
// Cascadable 8-bit magnitude comparator; the cascade inputs decide only when the bytes tie.
module eight_bit_comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       lin,
  input  logic       ein,
  input  logic       gin,
  output logic       less,
  output logic       equal,
  output logic       greater
);

  // Purely combinational byte compare with cascade pass-through on a tie.
  always_comb begin
    less    = 1'b0;
    equal   = 1'b0;
    greater = 1'b0;
    if (a < b) begin
      less = 1'b1;
    end else if (a > b) begin
      greater = 1'b1;
    end else begin
      less    = lin;
      equal   = ein;
      greater = gin;
    end
  end

endmodule

// File: rtl/wide_comparator_sequencer.sv
// Compares two NBYTES-wide operands one byte per clock, LSB first, reusing one
// eight_bit_comparator and feeding its registered result back as the cascade.
module wide_comparator_sequencer
  import cmp_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  signed_mode,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic                  less,
  output logic                  equal,
  output logic                  greater
);

  localparam int IDXW = $clog2(NBYTES);

  cmp_state_e          state_q;
  logic [IDXW-1:0]     idx_q;
  logic [8*NBYTES-1:0] a_q;
  logic [8*NBYTES-1:0] b_q;
  logic                signed_q;
  cmp_res_t            casc_q;
  cmp_res_t            res_q;
  logic                busy_q;
  logic                done_q;

  logic                last_s;
  logic [7:0]          byte_a_s;
  logic [7:0]          byte_b_s;
  cmp_res_t            cmp_s;

  // Byte select; the top byte gets its sign bit flipped so signed order becomes unsigned order.
  always_comb begin
    last_s   = (idx_q == IDXW'(NBYTES - 1));
    byte_a_s = a_q[8*int'(idx_q) +: 8];
    byte_b_s = b_q[8*int'(idx_q) +: 8];
    if (last_s && signed_q) begin
      byte_a_s[7] = ~byte_a_s[7];
      byte_b_s[7] = ~byte_b_s[7];
    end else begin
      byte_a_s = byte_a_s;
      byte_b_s = byte_b_s;
    end
  end

  eight_bit_comparator u_cmp (
    .a       (byte_a_s),
    .b       (byte_b_s),
    .lin     (casc_q.lt),
    .ein     (casc_q.eq),
    .gin     (casc_q.gt),
    .less    (cmp_s.lt),
    .equal   (cmp_s.eq),
    .greater (cmp_s.gt)
  );

  // Sequencing FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      casc_q   <= CASCADE_RESET;
      res_q    <= RESULT_RESET;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            idx_q    <= '0;
            casc_q   <= CASCADE_RESET;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (last_s) begin
            casc_q  <= cmp_s;
            res_q   <= cmp_s;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            casc_q  <= cmp_s;
            idx_q   <= idx_q + IDXW'(1);
            state_q <= ST_RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign less    = res_q.lt;
  assign equal   = res_q.eq;
  assign greater = res_q.gt;

endmodule

// File: tb/tb_wide_comparator_sequencer.sv
// Directed self-checking bench for wide_comparator_sequencer with NBYTES=4.
module tb_wide_comparator_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        signed_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        less;
  logic        equal;
  logic        greater;

  int n_checks;
  int n_errors;

  wide_comparator_sequencer #(.NBYTES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .less        (less),
    .equal       (equal),
    .greater     (greater)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [2:0] exp_leg);
    chk({tag, "_res"}, {29'd0, less, equal, greater}, {29'd0, exp_leg});
    chk({tag, "_onehot"}, 32'($countones({less, equal, greater})), 32'd1);
  endtask

  // Starts an op and leaves the bench positioned in the done cycle.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sm, input logic [2:0] exp_leg);
    a           = av;
    b           = bv;
    signed_mode = sm;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      tick();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk_res(tag, exp_leg);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    signed_mode = 1'b0;
    a           = 32'd0;
    b           = 32'd0;
    tick();
    tick();
    chk("rst_outs", {27'd0, busy, done, less, equal, greater}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_idle", {27'd0, busy, done, less, equal, greater}, 32'd0);

    run_op("uns_less", 32'h12345678, 32'h12345679, 1'b0, 3'b100);
    tick();
    chk("done_pulse", {31'd0, done}, 32'd0);
    run_op("equal", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b010);
    tick();
    run_op("uns_gt", 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b001);
    tick();
    run_op("sgn_less", 32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b100);
    tick();
    run_op("uns_gt2", 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b001);
    tick();
    run_op("sgn_eqtop", 32'h80000001, 32'h80000000, 1'b1, 3'b001);
    tick();

    // start while busy: second request in cycle 2 must be ignored
    a = 32'h00000005; b = 32'h00000003; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 32'h00000000; b = 32'h000000FF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("sib_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("sib_done", {31'd0, done}, 32'd1);
    chk_res("sib", 3'b001);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sib_single", {30'd0, busy, done}, 32'd0);
    end

    // abort in cycle 3 of a would-be "less" op
    a = 32'h00000001; b = 32'h00000002; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_nodone", {31'd0, done}, 32'd0);
      tick();
    end
    chk_res("abort_keep", 3'b001);

    // reset at edge 2 of a run
    a = 32'h00000001; b = 32'h00000002; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_outs", {27'd0, busy, done, less, equal, greater}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_nodone", {30'd0, busy, done}, 32'd0);
    end

    run_op("post_rst", 32'h00000100, 32'h000000FF, 1'b0, 3'b001);
    run_op("b2b", 32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b001);
    run_op("b2b2", 32'h00A00000, 32'h00A00001, 1'b0, 3'b100);
    tick();
    chk("final_idle", {30'd0, busy, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
